// File: rtl/irq_pkg.sv
// Shared types and constants for the machine-mode interrupt controller.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SVC
    } irq_state_e;

    localparam int unsigned IRQ_ID_W = 5;

    localparam logic [31:0] MCAUSE_IRQ = 32'h8000_0000;

endpackage

// File: rtl/irq_prio_arbiter.sv
// Rotate / find-first-set / un-rotate priority picker.
module irq_prio_arbiter
    import irq_pkg::*;
#(
    parameter int N_SRC = 16,
    parameter bit RR_EN = 1'b0
) (
    input  logic [N_SRC-1:0]    elig,
    input  logic [IRQ_ID_W-1:0] rr_ptr,
    output logic                valid,
    output logic [IRQ_ID_W-1:0] id
);

    logic [IRQ_ID_W-1:0] rot;
    logic [IRQ_ID_W:0]   lsh;
    logic [N_SRC-1:0]    rotated;
    logic [IRQ_ID_W-1:0] ffs;
    logic [IRQ_ID_W:0]   sum;

    assign rot     = RR_EN ? rr_ptr : '0;
    assign lsh     = (IRQ_ID_W+1)'(N_SRC) - {1'b0, rot};
    assign rotated = (elig >> rot) | (elig << lsh);
    assign valid   = |elig;

    always_comb begin
        ffs = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                ffs = IRQ_ID_W'(i);
            end
        end
    end

    // Undo the rotation, wrapping modulo N_SRC.
    always_comb begin
        sum = {1'b0, ffs} + {1'b0, rot};
        if (sum >= (IRQ_ID_W+1)'(N_SRC)) begin
            sum = sum - (IRQ_ID_W+1)'(N_SRC);
        end
    end

    assign id = sum[IRQ_ID_W-1:0];

endmodule

// File: rtl/irq_arbiter_ctrl.sv
// Machine-mode interrupt controller: pending capture, arbitration,
// single-claim trap FSM and per-source completion pulses.
module irq_arbiter_ctrl
    import irq_pkg::*;
#(
    parameter int N_SRC = 16,
    parameter bit RR_EN = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_SRC-1:0] int_req_i,
    input  logic [N_SRC-1:0] mie_i,
    input  logic [N_SRC-1:0] edge_mode_i,
    input  logic             int_ack_i,
    input  logic             int_rst_i,
    output logic             irq_o,
    output logic [31:0]      mcause_o,
    output logic [N_SRC-1:0] int_fin_o
);

    irq_state_e          state_q, state_d;
    logic [IRQ_ID_W-1:0] cur_id_q, cur_id_d;
    logic [IRQ_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [N_SRC-1:0]    req_q, req_d;
    logic [N_SRC-1:0]    epend_q, epend_d;
    logic [N_SRC-1:0]    fin_q, fin_d;
    logic                irq_q, irq_d;
    logic [31:0]         mcause_q, mcause_d;

    logic [N_SRC-1:0]    pend;
    logic [N_SRC-1:0]    elig;
    logic                arb_valid;
    logic [IRQ_ID_W-1:0] arb_id;

    assign req_d = int_req_i;
    assign pend  = (edge_mode_i & epend_q) | (~edge_mode_i & int_req_i);
    assign elig  = pend & mie_i;

    // A fresh edge in the completion cycle outranks the clear.
    assign epend_d = (epend_q & ~fin_d)
                   | (int_req_i & ~req_q & edge_mode_i);

    irq_prio_arbiter #(
        .N_SRC (N_SRC),
        .RR_EN (RR_EN)
    ) u_arb (
        .elig   (elig),
        .rr_ptr (rr_ptr_q),
        .valid  (arb_valid),
        .id     (arb_id)
    );

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        rr_ptr_d = rr_ptr_q;
        irq_d    = irq_q;
        mcause_d = mcause_q;
        fin_d    = '0;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d  = REQ;
                    cur_id_d = arb_id;
                    irq_d    = 1'b1;
                    mcause_d = MCAUSE_IRQ
                             | {{(32-IRQ_ID_W){1'b0}}, arb_id};
                end
            end
            REQ: begin
                if (int_ack_i) begin
                    state_d = SVC;
                    irq_d   = 1'b0;
                end
            end
            SVC: begin
                if (int_rst_i) begin
                    state_d = IDLE;
                    for (int i = 0; i < N_SRC; i++) begin
                        fin_d[i] = (cur_id_q == IRQ_ID_W'(i));
                    end
                    if (cur_id_q == IRQ_ID_W'(N_SRC - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = cur_id_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                irq_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cur_id_q <= '0;
            rr_ptr_q <= '0;
            req_q    <= '0;
            epend_q  <= '0;
            fin_q    <= '0;
            irq_q    <= 1'b0;
            mcause_q <= MCAUSE_IRQ;
        end else begin
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
            rr_ptr_q <= rr_ptr_d;
            req_q    <= req_d;
            epend_q  <= epend_d;
            fin_q    <= fin_d;
            irq_q    <= irq_d;
            mcause_q <= mcause_d;
        end
    end

    assign irq_o     = irq_q;
    assign mcause_o  = mcause_q;
    assign int_fin_o = fin_q;

endmodule

// File: doc/irq_arbiter_ctrl.md
# irq_arbiter_ctrl

Parametrised machine-mode interrupt controller for the RISC-V core. It collects up to 32 external interrupt sources and supports per-source edge or level sensitivity. It arbitrates with fixed or round-robin priority, presents a single trap request with its `mcause` to the CSR/trap unit, and pulses a per-source completion on `mret`.

## Interface
- `N_SRC`, default 16: number of sources, 1..32.
- `RR_EN`, default 0: selects the arbitration policy.
  - 0: fixed priority, lowest index wins.
  - 1: round-robin.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `int_req_i` in N_SRC: raw interrupt request lines, already synchronous to `clk_i`.
- `mie_i` in N_SRC: per-source enable, taken from the `mie` CSR.
- `edge_mode_i` in N_SRC: per-source sensitivity. 1 means rising-edge latched; 0 means level.
- `int_ack_i` in 1: the core has taken the trap. One-cycle pulse.
- `int_rst_i` in 1: the core has executed `mret`, so the handler is complete. One-cycle pulse.
- `irq_o` out 1: trap request to the core.
- `mcause_o` out 32: cause of the current claim.
- `int_fin_o` out N_SRC: one-hot completion pulse for the serviced source.

## Operation
- **Pending vector:**
  - Level source i: `pend[i] = int_req_i[i]`.
  - Edge source i: `pend[i]` is a register.
    - Set when `int_req_i[i]` is 1 and its registered previous value is 0.
    - Cleared when that source completes.
    - If a new edge and the clear occur in the same cycle, the set wins.
- **Eligibility:** `elig = pend & mie_i`.
- **Arbitration:**
  - `RR_EN=0`: the lowest set index of `elig`.
  - `RR_EN=1`: the first set index at or above `rr_ptr`, wrapping at N_SRC-1 back to 0.
  - `rr_ptr` resets to 0. On every completion it becomes `(id+1) mod N_SRC`.
- **FSM** (state enum):
  - IDLE:
    - If `elig` is nonzero, latch the winner into `cur_id` and go to REQ.
    - `irq_o` is 0.
  - REQ:
    - `irq_o` is 1.
    - On `int_ack_i`, go to SVC.
    - The claim is sticky: if `mie_i` or `int_req_i` drops, `irq_o` and `cur_id` are unchanged.
  - SVC:
    - `irq_o` is 0.
    - On `int_rst_i`:
      - `int_fin_o[cur_id]` pulses for 1 cycle.
      - Edge pending for `cur_id` clears.
      - `rr_ptr` updates.
      - Go to IDLE.
  - `int_rst_i` in IDLE or REQ, and `int_ack_i` in IDLE or SVC, are ignored.
- **Cause:** `mcause_o = {1'b1, 26'b0, cur_id[4:0]}`, with `cur_id` zero-extended. It is stable from REQ entry until the next claim.
- **Nesting:** not supported. No new claim is made until SVC exits.
- **Reset values:**
  - `irq_o` = 0, `int_fin_o` = 0, `mcause_o` = 32'h8000_0000.
  - `cur_id` = 0, all edge pending bits = 0, previous-request registers = 0.
  - State = IDLE, `rr_ptr` = 0.
- **Reset mid-operation:** `rst_i` at any point aborts the claim immediately and drops `irq_o` asynchronously. No `int_fin_o` pulse is issued.

## Timing
- Every output is registered, with no combinational path from input to output.
- Level source: request sampled at edge t while in IDLE gives `irq_o`=1 after edge t, a latency of 1 cycle.
- Edge source: the rising edge is detected at edge t and the pending bit sets there. Arbitration happens at t+1, so `irq_o` is 1 after t+1, a latency of 2 cycles.
- `int_ack_i` at edge t makes `irq_o` 0 after edge t.
- `int_rst_i` at edge t makes `int_fin_o` high for the cycle after t, and the state is IDLE.
- The earliest re-arbitration is at edge t+1. A still-asserted level source therefore re-claims with `irq_o` after t+1. This gap is 1 cycle.
- `int_fin_o` is never wider than 1 cycle and never has more than 1 bit set.

## Structure
- Package `irq_pkg` holds:
  - the FSM state enum `irq_state_e`: IDLE, REQ, SVC;
  - the constant `IRQ_ID_W = 5`;
  - the `mcause` interrupt-bit constant.
- Sub-module `irq_prio_arbiter`, parametrised by N_SRC and RR_EN:
  - inputs: `elig`, `rr_ptr`;
  - outputs: `valid`, `id`.
  - It is a rotate, find-first-set, un-rotate structure. With RR_EN=0 the rotation is tied to 0.
- The top level holds the pending and edge registers, the FSM, `rr_ptr`, and the output registers.

## Test plan
- **Fixed priority:** N_SRC=16, RR_EN=0, `mie_i`=16'hFFFF, level requests on sources 3 and 7 at once. Expected sequence:
  - `irq_o`=1 with `mcause_o`=32'h8000_0003.
  - Ack, then rst: `int_fin_o`=16'h0008.
  - 1 cycle later, `mcause_o`=32'h8000_0007.
- **Round-robin:** RR_EN=1, sources 0 and 2 held high through 4 claims.
  - Served order must be 0, 2, 0, 2.
  - `rr_ptr` after the first completion = 1.
- **Edge latching:** source 5 with `edge_mode_i`=1 is pulsed high for 1 cycle while another claim is in SVC.
  - The pulse stays pending, and `mcause_o`=32'h8000_0005 follows completion of the other claim.
  - A new edge on 5 in the same cycle as its `int_fin_o` leaves it pending, and it re-claims.
- **Masking and stickiness:**
  - `mie_i[4]`=0 with request 4 high: `irq_o` stays 0.
  - Drop `mie_i` while in REQ: `irq_o` stays 1 and `mcause_o` is unchanged.
- **Reset mid-SVC:** assert `rst_i` during SVC.
  - All outputs return to their reset values and no `int_fin_o` pulse is issued.
  - After release, a pending level source re-claims in 1 cycle.
- **Spurious handshakes:** `int_rst_i` in IDLE and `int_ack_i` in SVC must produce no state change and no pulse.
